dm_be_responder: RTL

DM_BE_RESPONDER -- requirements
Module: dm_be_responder

---
 rtl/dm_be_responder.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/dm_be_responder.sv
// dm_be_responder
//   Byte-enable data-memory responder: 1024 x 32-bit array behind a small
//   IDLE/WAIT/ACCESS/RESP handshake FSM. Stores merge right-justified wdata
//   into the lanes selected by BE; loads return the selected lanes shifted to
//   bit 0 and sign- or zero-extended.
//
//   Parameters:
//     WAIT_CYCLES   extra wait cycles before the array access (0..7)
//   Ports:
//     clk, rst_n            rising-edge clock, async active-low reset
//     req                   access request (only looked at in IDLE)
//     we                    1 = store, 0 = load
//     BE[3:0]               byte-lane enables
//     addr[11:0]            byte address (word index = addr[11:2])
//     wdata[31:0]           right-justified store data
//     MemReadSigned         1 = sign-extend load data
//     rdata[31:0]           registered, extended load data
//     ready                 one-cycle completion pulse
//     busy                  high while not IDLE
//     err                   illegal-BE flag, pulses with ready
//
//   Optional feature: define DM_BE_CHECK_EN to reject BE patterns other than
//   single byte, aligned half or full word (write suppressed, rdata held,
//   err raised with ready). Without it such patterns act as a full word.

module dm_be_responder #(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [3:0]  BE,
  input  logic [11:0] addr,
  input  logic [31:0] wdata,
  input  logic        MemReadSigned,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam logic [2:0] WC = 3'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t      state, state_nx;
  logic [2:0]  wcnt, wcnt_nx;

  logic        we_q;
  logic [3:0]  be_q;
  logic [9:0]  idx_q;
  logic [31:0] wd_q;
  logic        sg_q;

  logic [31:0] mem [1024];
  logic [31:0] mem_rd;
  logic [31:0] wrep;
  logic [31:0] wmask;
  logic [31:0] ld;
  logic [3:0]  be_eff;
  logic        be_ok;
  logic        do_wr;
  logic        do_rd;

  // Byte offset is implied by BE, so the low address bits carry no information.
  logic        addr_lsb_unused;
  assign addr_lsb_unused = ^addr[1:0];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    unique case (state)
      S_IDLE: begin
        if (req) begin
          if (WC != 3'd0) begin
            state_nx = S_WAIT;
            wcnt_nx  = WC;
          end else begin
            state_nx = S_ACCESS;
          end
        end
      end
      S_WAIT: begin
        if (wcnt <= 3'd1) begin
          state_nx = S_ACCESS;
          wcnt_nx  = '0;
        end else begin
          wcnt_nx  = wcnt - 3'd1;
        end
      end
      S_ACCESS: state_nx = S_RESP;
      S_RESP:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // ------------------------------------------------------ request capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q  <= 1'b0;
      be_q  <= '0;
      idx_q <= '0;
      wd_q  <= '0;
      sg_q  <= 1'b0;
    end else if (state == S_IDLE && req) begin
      we_q  <= we;
      be_q  <= BE;
      idx_q <= addr[11:2];
      wd_q  <= wdata;
      sg_q  <= MemReadSigned;
    end
  end

  // ------------------------------------------------------- lane decoding
  always_comb begin
    be_ok = (be_q == 4'b0001) || (be_q == 4'b0010) || (be_q == 4'b0100) ||
            (be_q == 4'b1000) || (be_q == 4'b0011) || (be_q == 4'b1100) ||
            (be_q == 4'b1111);
  end

`ifdef DM_BE_CHECK_EN
  assign be_eff = be_q;
  assign do_wr  = (state == S_ACCESS) &&  we_q && be_ok;
  assign do_rd  = (state == S_ACCESS) && !we_q && be_ok;
  assign err    = (state == S_RESP) && !be_ok;
`else
  assign be_eff = be_ok ? be_q : 4'b1111;
  assign do_wr  = (state == S_ACCESS) &&  we_q;
  assign do_rd  = (state == S_ACCESS) && !we_q;
  assign err    = 1'b0;
`endif

  assign mem_rd = mem[idx_q];

  // Replicating the right-justified data across lanes lets a plain lane mask
  // place it, whatever lane or half BE selects.
  always_comb begin
    case (be_eff)
      4'b0011, 4'b1100: wrep = {2{wd_q[15:0]}};
      4'b1111:          wrep = wd_q;
      default:          wrep = {4{wd_q[7:0]}};
    endcase
    wmask = {{8{be_eff[3]}}, {8{be_eff[2]}}, {8{be_eff[1]}}, {8{be_eff[0]}}};
  end

  always_comb begin
    case (be_eff)
      4'b0001: ld = {{24{sg_q & mem_rd[7]}},  mem_rd[7:0]};
      4'b0010: ld = {{24{sg_q & mem_rd[15]}}, mem_rd[15:8]};
      4'b0100: ld = {{24{sg_q & mem_rd[23]}}, mem_rd[23:16]};
      4'b1000: ld = {{24{sg_q & mem_rd[31]}}, mem_rd[31:24]};
      4'b0011: ld = {{16{sg_q & mem_rd[15]}}, mem_rd[15:0]};
      4'b1100: ld = {{16{sg_q & mem_rd[31]}}, mem_rd[31:16]};
      default: ld = mem_rd;
    endcase
  end

  // ------------------------------------------------------------- storage
  // Array contents are not reset; an asserted reset has already pulled the
  // state out of ACCESS, which is what aborts an in-flight store.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[idx_q] <= (mem_rd & ~wmask) | (wrep & wmask);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (do_rd) begin
      rdata <= ld;
    end
  end

  assign ready = (state == S_RESP);
  assign busy  = (state != S_IDLE);

endmodule
